// File: rtl/timer_countdown_core_pkg.sv
// Shared encodings, field widths and the preset payload for the countdown timer.
package timer_pkg;

  localparam int unsigned MS_W    = 10;
  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned HR_W    = 5;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned SEL_W   = 2;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_INIT   = 3'd0;
  localparam state_t ST_FINISH = 3'd1;
  localparam state_t ST_PAUSE  = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_SET    = 3'd4;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_SEC = 2'd0;
  localparam sel_t SEL_MIN = 2'd1;
  localparam sel_t SEL_HR  = 2'd2;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } preset_t;

endpackage

// File: rtl/timer_countdown_core_mod_counter.sv
// Wrapping 0..MAX field counter with load, edit up/down and a borrow chain link.
module timer_mod_counter #(
  parameter int unsigned W   = 6,
  parameter int unsigned MAX = 59
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_up,
  input  logic         i_down,
  input  logic         i_bin,
  output logic [W-1:0] o_val,
  output logic         o_bout_c
);

  logic [W-1:0] r_val;
  logic         w_dec;
  logic         w_inc;
  logic         w_at_zero;
  logic         w_at_max;

  // A borrow-in always decrements; edit up/down pressed together cancel.
  assign w_dec     = i_bin | (i_down & ~i_up);
  assign w_inc     = i_up & ~i_down & ~i_bin;
  assign w_at_zero = (r_val == '0);
  assign w_at_max  = (r_val == W'(MAX));

  // Only chain decrements propagate a borrow; edit wraps stay local to the field.
  assign o_bout_c  = i_bin & w_at_zero;

  // Field value register: load beats decrement beats increment.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_val <= '0;
    end else if (i_load) begin
      r_val <= i_load_val;
    end else if (w_dec) begin
      r_val <= w_at_zero ? W'(MAX) : r_val - W'(1);
    end else if (w_inc) begin
      r_val <= w_at_max ? '0 : r_val + W'(1);
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/timer_countdown_core.sv
// Countdown timer: button-driven preset editing, ms-tick countdown, alarm / auto-reload.
module timer_countdown_core
  import timer_pkg::*;
#(
  parameter int unsigned MS_PER_SEC = 1000,
  parameter int unsigned HR_MAX     = 23,
  parameter int unsigned ALARM_MS   = 3000
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_ms_pulse,
  input  logic               i_set,
  input  logic               i_up,
  input  logic               i_down,
  input  logic               i_left,
  input  logic               i_right,
  input  logic               i_repeat,
  output logic [MS_W-1:0]    o_ms,
  output logic [SEC_W-1:0]   o_sec,
  output logic [MIN_W-1:0]   o_min,
  output logic [HR_W-1:0]    o_hr,
  output logic [STATE_W-1:0] o_state,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_finish_pulse,
  output logic               o_alarm
);

  localparam int unsigned ACNT_W = (ALARM_MS > 1) ? $clog2(ALARM_MS + 1) : 1;

  if ((MS_PER_SEC == 0) || (MS_PER_SEC > (1 << MS_W))) begin : g_bad_ms_per_sec
    $error("timer_countdown_core: MS_PER_SEC must be in 1..1024");
  end
  if (HR_MAX > ((1 << HR_W) - 1)) begin : g_bad_hr_max
    $error("timer_countdown_core: HR_MAX does not fit the hour field");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  sel_t                r_sel;
  sel_t                w_sel_nxt;
  preset_t             r_preset;
  logic                r_finish_pulse;
  logic                r_reload;
  logic                r_alarm;
  logic [ACNT_W-1:0]   r_alarm_cnt;

  logic [MS_W-1:0]     w_ms;
  logic [SEC_W-1:0]    w_sec;
  logic [MIN_W-1:0]    w_min;
  logic [HR_W-1:0]     w_hr;
  logic                w_ms_bout;
  logic                w_sec_bout;
  logic                w_min_bout;
  logic                w_hr_bout_unused;

  logic                w_rlud;
  logic                w_all_zero;
  logic                w_tick_dec;
  logic                w_last;
  logic                w_load_preset;
  logic                w_ms_clr;
  logic                w_edit_up;
  logic                w_edit_down;
  logic                w_preset_we;
  logic                w_alarm_clr;

  assign w_rlud     = i_up | i_down | i_left | i_right;
  assign w_all_zero = (w_sec == '0) && (w_min == '0) && (w_hr == '0);

  // A tick counts only in RUN and is dropped when i_set wins the same cycle.
  assign w_tick_dec = (r_state == ST_RUN) & i_ms_pulse & ~i_set;
  assign w_last     = w_tick_dec & (w_ms == MS_W'(1)) & w_all_zero;

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; i_set is always the highest-priority event.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (i_set) w_state_nxt = ST_SET;
      end
      ST_SET: begin
        if (i_set) w_state_nxt = w_all_zero ? ST_INIT : ST_PAUSE;
      end
      ST_PAUSE: begin
        if (i_set)       w_state_nxt = ST_SET;
        else if (w_rlud) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_set)       w_state_nxt = ST_SET;
        else if (w_last) w_state_nxt = ST_FINISH;
        else if (w_rlud) w_state_nxt = ST_PAUSE;
      end
      ST_FINISH: begin
        if (i_set)         w_state_nxt = ST_SET;
        else if (w_rlud)   w_state_nxt = ST_INIT;
        else if (r_reload) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Datapath controls decoded from the current state and buttons.
  always_comb begin
    w_load_preset = 1'b0;
    w_ms_clr      = 1'b0;
    w_edit_up     = 1'b0;
    w_edit_down   = 1'b0;
    w_preset_we   = 1'b0;
    w_alarm_clr   = 1'b0;
    w_sel_nxt     = r_sel;
    case (r_state)
      ST_INIT: begin
        w_load_preset = i_set;
      end
      ST_SET: begin
        if (i_set) begin
          w_ms_clr    = 1'b1;
          w_preset_we = ~w_all_zero;
        end else begin
          w_edit_up   = i_up & ~i_down;
          w_edit_down = i_down & ~i_up;
          if (i_right & ~i_left) begin
            w_sel_nxt = (r_sel == SEL_HR) ? SEL_SEC : r_sel + 2'd1;
          end else if (i_left & ~i_right) begin
            w_sel_nxt = (r_sel == SEL_SEC) ? SEL_HR : r_sel - 2'd1;
          end
        end
      end
      ST_FINISH: begin
        w_alarm_clr   = i_set | w_rlud;
        w_load_preset = i_set | (~w_rlud & r_reload);
      end
      default: ;
    endcase
    if (i_set) w_sel_nxt = SEL_SEC;
  end

  timer_mod_counter #(.W(MS_W), .MAX(MS_PER_SEC - 1)) u_ms (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_load     (w_load_preset | w_ms_clr),
    .i_load_val ('0),
    .i_up       (1'b0),
    .i_down     (1'b0),
    .i_bin      (w_tick_dec),
    .o_val      (w_ms),
    .o_bout_c   (w_ms_bout)
  );

  timer_mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_load     (w_load_preset),
    .i_load_val (r_preset.sec),
    .i_up       (w_edit_up & (r_sel == SEL_SEC)),
    .i_down     (w_edit_down & (r_sel == SEL_SEC)),
    .i_bin      (w_ms_bout),
    .o_val      (w_sec),
    .o_bout_c   (w_sec_bout)
  );

  timer_mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_load     (w_load_preset),
    .i_load_val (r_preset.min),
    .i_up       (w_edit_up & (r_sel == SEL_MIN)),
    .i_down     (w_edit_down & (r_sel == SEL_MIN)),
    .i_bin      (w_sec_bout),
    .o_val      (w_min),
    .o_bout_c   (w_min_bout)
  );

  timer_mod_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_load     (w_load_preset),
    .i_load_val (r_preset.hr),
    .i_up       (w_edit_up & (r_sel == SEL_HR)),
    .i_down     (w_edit_down & (r_sel == SEL_HR)),
    .i_bin      (w_min_bout),
    .o_val      (w_hr),
    .o_bout_c   (w_hr_bout_unused)
  );

  // Field selector, preset capture, finish strobe and one-shot reload flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sel          <= SEL_SEC;
      r_preset       <= '0;
      r_finish_pulse <= 1'b0;
      r_reload       <= 1'b0;
    end else begin
      r_sel          <= w_sel_nxt;
      if (w_preset_we) r_preset <= {w_hr, w_min, w_sec};
      r_finish_pulse <= w_last;
      r_reload       <= w_last & i_repeat;
    end
  end

  // Alarm level: armed at finish unless repeating, timed out in ticks (0 = hold until ack).
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_alarm     <= 1'b0;
      r_alarm_cnt <= '0;
    end else if (w_last && !i_repeat) begin
      r_alarm     <= 1'b1;
      r_alarm_cnt <= ACNT_W'(ALARM_MS);
    end else if (w_alarm_clr) begin
      r_alarm     <= 1'b0;
    end else if (r_alarm && i_ms_pulse && (ALARM_MS != 0)) begin
      r_alarm_cnt <= r_alarm_cnt - ACNT_W'(1);
      if (r_alarm_cnt == ACNT_W'(1)) r_alarm <= 1'b0;
    end
  end

  assign o_ms           = w_ms;
  assign o_sec          = w_sec;
  assign o_min          = w_min;
  assign o_hr           = w_hr;
  assign o_state        = r_state;
  assign o_sel          = r_sel;
  assign o_finish_pulse = r_finish_pulse;
  assign o_alarm        = r_alarm;

endmodule

// File: tb/tb_timer_countdown_core.sv
// Self-checking bench: directed scenarios plus random buttons against a total-ms reference model.
module tb_timer_countdown_core;
  import timer_pkg::*;

  localparam int MSPS = 1000;
  localparam int HRM  = 23;
  localparam int ALM  = 3000;

  logic i_clk = 1'b0;
  logic i_rstn = 1'b1;
  logic i_ms_pulse = 1'b0, i_set = 1'b0, i_up = 1'b0, i_down = 1'b0;
  logic i_left = 1'b0, i_right = 1'b0, i_repeat = 1'b0;
  logic [9:0] o_ms;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hr;
  logic [2:0] o_state;
  logic [1:0] o_sel;
  logic       o_finish_pulse, o_alarm;

  timer_countdown_core #(.MS_PER_SEC(MSPS), .HR_MAX(HRM), .ALARM_MS(ALM)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_ms_pulse(i_ms_pulse), .i_set(i_set),
    .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right),
    .i_repeat(i_repeat), .o_ms(o_ms), .o_sec(o_sec), .o_min(o_min), .o_hr(o_hr),
    .o_state(o_state), .o_sel(o_sel), .o_finish_pulse(o_finish_pulse), .o_alarm(o_alarm)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the count is one integer of milliseconds; fields are derived.
  logic [2:0] m_state;
  int m_total, m_sel, m_preset_s, m_alarm_left;
  bit m_fin, m_alarm, m_reload;

  task automatic model_reset();
    m_state = ST_INIT; m_total = 0; m_sel = 0; m_preset_s = 0;
    m_alarm_left = 0; m_fin = 0; m_alarm = 0; m_reload = 0;
  endtask

  task automatic model_step(input bit s, u, d, l, r, t);
    int hr, mn, sc, ms, tot_s;
    bit rlud, fin, rel;
    rlud = u | d | l | r; fin = 0; rel = 0;
    ms = m_total % MSPS;
    sc = (m_total / MSPS) % 60;
    mn = (m_total / (MSPS * 60)) % 60;
    hr = m_total / (MSPS * 3600);
    if (s) m_sel = 0;
    case (m_state)
      ST_INIT: if (s) begin m_state = ST_SET; m_total = m_preset_s * MSPS; end
      ST_SET: begin
        if (s) begin
          tot_s = hr * 3600 + mn * 60 + sc;
          m_total = tot_s * MSPS;
          if (tot_s == 0) m_state = ST_INIT;
          else begin m_state = ST_PAUSE; m_preset_s = tot_s; end
        end else begin
          if (u != d) begin
            case (m_sel)
              0: sc = u ? (sc + 1) % 60 : (sc + 59) % 60;
              1: mn = u ? (mn + 1) % 60 : (mn + 59) % 60;
              default: hr = u ? (hr + 1) % (HRM + 1) : (hr + HRM) % (HRM + 1);
            endcase
            m_total = (hr * 3600 + mn * 60 + sc) * MSPS + ms;
          end
          if (r && !l) m_sel = (m_sel + 1) % 3;
          else if (l && !r) m_sel = (m_sel + 2) % 3;
        end
      end
      ST_PAUSE: if (s) m_state = ST_SET; else if (rlud) m_state = ST_RUN;
      ST_RUN: begin
        if (s) m_state = ST_SET;
        else begin
          if (t) m_total = m_total - 1;
          if (t && m_total == 0) begin m_state = ST_FINISH; fin = 1; rel = i_repeat; end
          else if (rlud) m_state = ST_PAUSE;
        end
      end
      default: begin
        if (s) begin m_state = ST_SET; m_total = m_preset_s * MSPS; m_alarm = 0; end
        else if (rlud) begin m_state = ST_INIT; m_alarm = 0; end
        else if (m_reload) begin m_state = ST_RUN; m_total = m_preset_s * MSPS; end
        else if (m_alarm && t) begin
          m_alarm_left = m_alarm_left - 1;
          if (m_alarm_left == 0) m_alarm = 0;
        end
      end
    endcase
    if (fin && !rel) begin m_alarm = 1; m_alarm_left = ALM; end
    m_fin = fin; m_reload = rel;
  endtask

  function automatic logic [33:0] exp_vec();
    int hr, mn, sc, ms;
    ms = m_total % MSPS;
    sc = (m_total / MSPS) % 60;
    mn = (m_total / (MSPS * 60)) % 60;
    hr = m_total / (MSPS * 3600);
    return {m_state, 2'(m_sel), 5'(hr), 6'(mn), 6'(sc), 10'(ms), m_fin, m_alarm};
  endfunction

  function automatic logic [33:0] act_vec();
    return {o_state, o_sel, o_hr, o_min, o_sec, o_ms, o_finish_pulse, o_alarm};
  endfunction

  // One clock of stimulus; the model advances in lockstep, outputs sampled 1 time unit after the edge.
  task automatic cycle(input bit s, u, d, l, r, t);
    i_set = s; i_up = u; i_down = d; i_left = l; i_right = r; i_ms_pulse = t;
    model_step(s, u, d, l, r, t);
    @(posedge i_clk); #1;
    i_set = 0; i_up = 0; i_down = 0; i_left = 0; i_right = 0; i_ms_pulse = 0;
  endtask

  task automatic do_reset();
    #2 i_rstn = 1'b0;
    model_reset();
    @(negedge i_clk) i_rstn = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    model_reset();
    #1 i_rstn = 1'b0;
    #2;
    if (act_vec() !== 34'd0) begin
      errors++; $display("FAIL reset_values: got %h want %h", act_vec(), 34'd0);
    end
    checks++;
    @(negedge i_clk) i_rstn = 1'b1;
    @(posedge i_clk); #1;
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_release: got %h want %h", act_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_set_edit();
    cycle(1,0,0,0,0,0);
    for (int i = 0; i < 3; i++) cycle(0,1,0,0,0,0);
    cycle(0,0,0,0,1,0);
    cycle(0,1,0,0,0,0);
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL set_edit_model: got %h want %h", act_vec(), exp_vec());
    end
    checks++;
    cycle(1,0,0,0,0,0);
    if (o_sec !== 6'd3 || o_min !== 6'd1 || o_hr !== 5'd0 || o_ms !== 10'd0 || o_state !== ST_PAUSE) begin
      errors++; $display("FAIL set_exit_pause: got st=%0d %0d:%0d:%0d.%0d want st=%0d 0:1:3.0",
                         o_state, o_hr, o_min, o_sec, o_ms, ST_PAUSE);
    end
    checks++;
  endtask

  task automatic test_countdown();
    int fin_cnt, alarm_ticks;
    bit a;
    fin_cnt = 0; alarm_ticks = 0;
    cycle(0,1,0,0,0,0);
    if (o_state !== ST_RUN) begin
      errors++; $display("FAIL pause_to_run: got %0d want %0d", o_state, ST_RUN);
    end
    checks++;
    for (int i = 0; i < 63000; i++) begin
      cycle(0,0,0,0,0,1);
      if (o_finish_pulse) fin_cnt++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL countdown tick %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      checks++;
    end
    if (o_state !== ST_FINISH || o_alarm !== 1'b1) begin
      errors++; $display("FAIL countdown_zero: got st=%0d alarm=%0d want st=%0d alarm=1", o_state, o_alarm, ST_FINISH);
    end
    checks++;
    for (int i = 0; i < 3100; i++) begin
      a = o_alarm;
      cycle(0,0,0,0,0,1);
      if (a) alarm_ticks++;
      if (o_finish_pulse) fin_cnt++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL alarm tick %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      checks++;
    end
    if (fin_cnt !== 1) begin
      errors++; $display("FAIL finish_pulse_count: got %0d want 1", fin_cnt);
    end
    checks++;
    if (alarm_ticks !== ALM) begin
      errors++; $display("FAIL alarm_duration: got %0d want %0d", alarm_ticks, ALM);
    end
    checks++;
    cycle(0,0,0,0,1,0);
    if (o_state !== ST_INIT) begin
      errors++; $display("FAIL finish_rlud_init: got %0d want %0d", o_state, ST_INIT);
    end
    checks++;
  endtask

  task automatic test_wrap();
    cycle(1,0,0,0,0,0);
    for (int i = 0; i < 4; i++) cycle(0,0,1,0,0,0);
    if (o_sec !== 6'd59) begin
      errors++; $display("FAIL sec_wrap_down: got %0d want 59", o_sec);
    end
    checks++;
    cycle(0,0,0,0,1,0);
    cycle(0,0,0,0,1,0);
    cycle(0,0,1,0,0,0);
    if (o_hr !== 5'(HRM) || o_sel !== SEL_HR) begin
      errors++; $display("FAIL hr_wrap_down: got hr=%0d sel=%0d want hr=%0d sel=2", o_hr, o_sel, HRM);
    end
    checks++;
    cycle(0,0,0,1,1,0);
    if (o_sel !== SEL_HR) begin
      errors++; $display("FAIL left_right_ignored: got %0d want 2", o_sel);
    end
    checks++;
    cycle(0,1,1,0,0,0);
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL up_down_ignored: got %h want %h", act_vec(), exp_vec());
    end
    checks++;
    cycle(1,1,0,0,0,0);
    if (act_vec() !== exp_vec() || o_state !== ST_PAUSE) begin
      errors++; $display("FAIL set_beats_edit: got %h want %h", act_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_finish_priority();
    do_reset();
    cycle(1,0,0,0,0,0);
    cycle(0,1,0,0,0,0);
    cycle(1,0,0,0,0,0);
    cycle(0,0,0,1,0,0);
    for (int i = 0; i < 999; i++) cycle(0,0,0,0,0,1);
    if (o_ms !== 10'd1 || o_sec !== 6'd0 || o_state !== ST_RUN) begin
      errors++; $display("FAIL one_ms_left: got st=%0d sec=%0d ms=%0d want st=%0d sec=0 ms=1", o_state, o_sec, o_ms, ST_RUN);
    end
    checks++;
    cycle(0,0,0,1,0,1);
    if (o_state !== ST_FINISH || o_finish_pulse !== 1'b1) begin
      errors++; $display("FAIL tick_beats_left: got st=%0d fin=%0d want st=%0d fin=1", o_state, o_finish_pulse, ST_FINISH);
    end
    checks++;
    cycle(0,0,1,0,0,0);
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL finish_ack: got %h want %h", act_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_zero_exit();
    int fin_cnt;
    fin_cnt = 0;
    do_reset();
    cycle(1,0,0,0,0,0);
    if (o_state !== ST_SET) begin
      errors++; $display("FAIL init_to_set: got %0d want %0d", o_state, ST_SET);
    end
    checks++;
    cycle(1,0,0,0,0,0);
    if (o_finish_pulse) fin_cnt++;
    cycle(0,0,0,0,0,0);
    if (o_finish_pulse) fin_cnt++;
    if (o_state !== ST_INIT || fin_cnt !== 0) begin
      errors++; $display("FAIL zero_exit: got st=%0d fin=%0d want st=%0d fin=0", o_state, fin_cnt, ST_INIT);
    end
    checks++;
  endtask

  task automatic test_repeat();
    int fin_cnt;
    fin_cnt = 0;
    do_reset();
    i_repeat = 1'b1;
    cycle(1,0,0,0,0,0);
    cycle(0,1,0,0,0,0);
    cycle(0,1,0,0,0,0);
    cycle(1,0,0,0,0,0);
    cycle(0,0,0,0,1,0);
    for (int i = 0; i < 2000; i++) begin
      cycle(0,0,0,0,0,1);
      if (o_finish_pulse) fin_cnt++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL repeat tick %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      checks++;
    end
    if (fin_cnt !== 1 || o_state !== ST_FINISH || o_alarm !== 1'b0) begin
      errors++; $display("FAIL repeat_finish: got fin=%0d st=%0d alarm=%0d want fin=1 st=%0d alarm=0",
                         fin_cnt, o_state, o_alarm, ST_FINISH);
    end
    checks++;
    cycle(0,0,0,0,0,1);
    if (o_state !== ST_RUN || o_sec !== 6'd2 || o_ms !== 10'd0 || o_alarm !== 1'b0) begin
      errors++; $display("FAIL repeat_reload: got st=%0d sec=%0d ms=%0d alarm=%0d want st=%0d sec=2 ms=0 alarm=0",
                         o_state, o_sec, o_ms, o_alarm, ST_RUN);
    end
    checks++;
    for (int i = 0; i < 500; i++) begin
      cycle(0,0,0,0,0,1);
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL repeat_resume tick %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      checks++;
    end
    #2 i_rstn = 1'b0;
    #1;
    if (act_vec() !== 34'd0) begin
      errors++; $display("FAIL async_reset_mid_run: got %h want %h", act_vec(), 34'd0);
    end
    checks++;
    model_reset();
    i_repeat = 1'b0;
    @(negedge i_clk) i_rstn = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_random();
    bit s, u, d, l, r, t;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i % 500 == 0) i_repeat = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 39) == 0);
      u = ($urandom_range(0, 11) == 0);
      d = ($urandom_range(0, 11) == 0);
      l = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 11) == 0);
      t = 1'($urandom_range(0, 1));
      cycle(s, u, d, l, r, t);
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h want %h", i, act_vec(), exp_vec());
      end
      checks++;
    end
    i_repeat = 1'b0;
  endtask

  initial begin
    test_reset();
    test_set_edit();
    test_countdown();
    test_wrap();
    test_finish_priority();
    test_zero_exit();
    test_repeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
